// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze / bubble / flush sequencing for the five-stage core
//   (data-memory wait FSM, decode RAW interlock, EX redirect squash, stall counter).
// Latency: control outputs are combinational from inputs + FSM state; dmem_busy and
//   stall_cnt are registered (visible one cycle after the qualifying edge).
// Backpressure: mem_stall freezes every pipeline register and the PC until dmem_done;
//   a RAW hazard holds PC and IF/ID while ID/EX takes a bubble.
// Build option: define HAZ_FORWARDING_EN when the EX/MEM->EX forwarding network exists
//   (only load-use against EX interlocks); undefined, any RAW against EX or MEM interlocks.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs1,
  input  logic [2:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic             ex_RegWrt,
  input  logic [2:0]       ex_write_reg,
  input  logic             ex_is_load,
  input  logic             mem_valid,
  input  logic             mem_RegWrt,
  input  logic [2:0]       mem_write_reg,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_done,
  output logic             mem_stall,
  output logic             hold_pc,
  output logic             hold_ifid,
  output logic             send_nop,
  output logic             flush_ifid,
  output logic             dmem_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_wait;   // memory freeze condition before reset gating
  logic ex_match;   // decode reads the EX destination
  logic haz;        // RAW interlock request
  logic stall_evt;  // this cycle counts as a stalled cycle

  // Source-register comparison against the EX-stage destination.
  assign ex_match = (id_rs1_used && (id_rs1 == ex_write_reg)) ||
                    (id_rs2_used && (id_rs2 == ex_write_reg));

`ifdef HAZ_FORWARDING_EN
  // Forwarding covers every ALU producer; only a load still in EX has no data yet.
  assign haz = id_valid && ex_valid && ex_RegWrt && ex_is_load && ex_match;

  // MEM-stage producers are served by the forwarding network.
  logic unused_mem_ports;
  assign unused_mem_ports = ^{mem_valid, mem_RegWrt, mem_write_reg};
`else
  logic mem_match;

  assign mem_match = (id_rs1_used && (id_rs1 == mem_write_reg)) ||
                     (id_rs2_used && (id_rs2 == mem_write_reg));

  // Without forwarding every in-flight producer in EX or MEM blocks decode;
  // WB is safe because the register file bypasses same-cycle writes.
  assign haz = id_valid &&
               ((ex_valid  && ex_RegWrt  && ex_match) ||
                (mem_valid && mem_RegWrt && mem_match));

  // Load-ness is irrelevant when every producer interlocks.
  logic unused_load_flag;
  assign unused_load_flag = ex_is_load;
`endif

  // A single-cycle access (done together with req) never freezes; in DWAIT a
  // new req is meaningless because the MEM stage is already frozen.
  assign mem_wait = ((state_q == RUN)   && dmem_req && !dmem_done) ||
                    ((state_q == DWAIT) && !dmem_done);

  // Memory-wait FSM state register; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-wait FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_done) begin
          state_d = DWAIT;
        end
      end
      DWAIT: begin
        if (dmem_done) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Pipeline controls, highest priority first: memory freeze (EX is frozen, so a
  // pending redirect waits), redirect squash (decode is discarded, so its hazard
  // is moot), RAW interlock. Everything is quiet while reset is held.
  always_comb begin
    mem_stall  = 1'b0;
    hold_pc    = 1'b0;
    hold_ifid  = 1'b0;
    send_nop   = 1'b0;
    flush_ifid = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        mem_stall = 1'b1;
        hold_pc   = 1'b1;
        hold_ifid = 1'b1;
      end else if (ex_redirect) begin
        flush_ifid = 1'b1;
        send_nop   = 1'b1;
      end else if (haz) begin
        hold_pc   = 1'b1;
        hold_ifid = 1'b1;
        send_nop  = 1'b1;
      end
    end
  end

  // A squashed decode does not count: its hazard never costs a cycle.
  assign stall_evt = mem_wait || (haz && !ex_redirect);

  // Saturating stall-cycle counter next value; pinned at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem_busy = (state_q == DWAIT);
  assign stall_cnt = stall_cnt_q;

endmodule
